// File: rtl/bank_cmd_arbiter_pkg.sv
// Shared types and default timing constants for the DRAM command-bus arbiter.
package bank_cmd_arbiter_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4,
    REF = 3'd5
  } cmd_code_t;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_t;

  localparam int DEF_T_RRD = 2;
  localparam int DEF_T_CCD = 2;
  localparam int DEF_T_WTR = 4;
  localparam int DEF_T_RTW = 3;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/bank_cmd_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_BANKS = 8,
  parameter int IDX_W     = $clog2(NUM_BANKS)
) (
  input  logic [NUM_BANKS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_BANKS-1:0] gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_vld
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    cand    = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int off = NUM_BANKS - 1; off >= 0; off--) begin
      cand = ptr + IDX_W'(off);
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = gnt_vld ? (NUM_BANKS'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Arbitrates the shared DRAM command bus among the bank FSMs, enforcing
// inter-bank timing and registering the winning command toward the PHY.
module bank_cmd_arbiter
  import bank_cmd_arbiter_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int ADDR_BITS = 16,
  parameter int T_RRD     = DEF_T_RRD,
  parameter int T_CCD     = DEF_T_CCD,
  parameter int T_WTR     = DEF_T_WTR,
  parameter int T_RTW     = DEF_T_RTW,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int IDX_W     = $clog2(NUM_BANKS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_BANKS-1:0]           ba_issue,
  input  logic [NUM_BANKS*3-1:0]         ba_cmd,
  input  logic [NUM_BANKS*ADDR_BITS-1:0] ba_addr,
  output logic [NUM_BANKS-1:0]           stall,
  output logic                           cmd_valid,
  output logic [2:0]                     cmd_code,
  output logic [IDX_W-1:0]               cmd_bank,
  output logic [ADDR_BITS-1:0]           cmd_addr,
  output logic                           bus_dir
);

  localparam logic [CNT_W-1:0] RRD_LD = CNT_W'(T_RRD - 1);
  localparam logic [CNT_W-1:0] CCD_LD = CNT_W'(T_CCD - 1);
  localparam logic [CNT_W-1:0] WTR_LD = CNT_W'(T_WTR - 1);
  localparam logic [CNT_W-1:0] RTW_LD = CNT_W'(T_RTW - 1);

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  cmd_code_t              bank_cmd [NUM_BANKS];
  logic [NUM_BANKS-1:0]   elig;
  logic [NUM_BANKS-1:0]   ref_req;
  logic [NUM_BANKS-1:0]   ref_oh;
  logic [NUM_BANKS-1:0]   rr_gnt;
  logic [NUM_BANKS-1:0]   gnt_oh;
  logic [IDX_W-1:0]       ref_idx;
  logic [IDX_W-1:0]       rr_idx;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   ref_vld;
  logic                   rr_vld;
  logic                   gnt_vld;
  cmd_code_t              gnt_cmd;
  logic [ADDR_BITS-1:0]   gnt_addr;

  logic                   cmd_valid_q, cmd_valid_d;
  cmd_code_t              cmd_code_q, cmd_code_d;
  logic [IDX_W-1:0]       cmd_bank_q, cmd_bank_d;
  logic [ADDR_BITS-1:0]   cmd_addr_q, cmd_addr_d;
  dir_t                   dir_q, dir_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       rrd_cnt_q, rrd_cnt_d;
  logic [CNT_W-1:0]       ccd_cnt_q, ccd_cnt_d;
  logic [CNT_W-1:0]       wtr_cnt_q, wtr_cnt_d;
  logic [CNT_W-1:0]       rtw_cnt_q, rtw_cnt_d;

  // Per-bank eligibility against the shared timing counters.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_cmd[i] = cmd_code_t'(ba_cmd[i*3 +: 3]);
      elig[i]     = 1'b0;
      ref_req[i]  = 1'b0;
      if (ba_issue[i]) begin
        case (bank_cmd[i])
          ACT:     elig[i] = (rrd_cnt_q == '0);
          RD:      elig[i] = (ccd_cnt_q == '0) && (wtr_cnt_q == '0);
          WR:      elig[i] = (ccd_cnt_q == '0) && (rtw_cnt_q == '0);
          PRE:     elig[i] = 1'b1;
          REF: begin
            elig[i]    = 1'b1;
            ref_req[i] = 1'b1;
          end
          default: elig[i] = 1'b0;
        endcase
      end
    end
  end

  // Refresh bypasses the rotation: lowest-index REF requester wins.
  always_comb begin
    ref_vld = |ref_req;
    ref_idx = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (ref_req[i]) ref_idx = IDX_W'(i);
    end
    ref_oh = ref_vld ? (NUM_BANKS'(1) << ref_idx) : '0;
  end

  rr_arbiter #(
    .NUM_BANKS (NUM_BANKS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .req     (elig),
    .ptr     (rr_ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  always_comb begin
    gnt_vld  = ref_vld | rr_vld;
    gnt_idx  = ref_vld ? ref_idx : rr_idx;
    gnt_oh   = ref_vld ? ref_oh : rr_gnt;
    gnt_cmd  = bank_cmd[gnt_idx];
    gnt_addr = ba_addr[gnt_idx*ADDR_BITS +: ADDR_BITS];
  end

  // Non-issuing banks are never stalled so their own timers keep running.
  assign stall = rst_n ? (ba_issue & ~gnt_oh) : '0;

  always_comb begin
    cmd_valid_d = gnt_vld;
    cmd_code_d  = gnt_vld ? gnt_cmd : NOP;
    cmd_bank_d  = gnt_vld ? gnt_idx : cmd_bank_q;
    cmd_addr_d  = gnt_vld ? gnt_addr : cmd_addr_q;
    rr_ptr_d    = (gnt_vld && !ref_vld) ? gnt_idx + IDX_W'(1) : rr_ptr_q;

    rrd_cnt_d = sat_dec(rrd_cnt_q);
    ccd_cnt_d = sat_dec(ccd_cnt_q);
    wtr_cnt_d = sat_dec(wtr_cnt_q);
    rtw_cnt_d = sat_dec(rtw_cnt_q);
    dir_d     = dir_q;
    if (gnt_vld) begin
      case (gnt_cmd)
        ACT: rrd_cnt_d = RRD_LD;
        RD: begin
          ccd_cnt_d = CCD_LD;
          rtw_cnt_d = RTW_LD;
          dir_d     = DIR_RD;
        end
        WR: begin
          ccd_cnt_d = CCD_LD;
          wtr_cnt_d = WTR_LD;
          dir_d     = DIR_WR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= NOP;
      cmd_bank_q  <= '0;
      cmd_addr_q  <= '0;
      dir_q       <= DIR_RD;
      rr_ptr_q    <= '0;
      rrd_cnt_q   <= '0;
      ccd_cnt_q   <= '0;
      wtr_cnt_q   <= '0;
      rtw_cnt_q   <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_addr_q  <= cmd_addr_d;
      dir_q       <= dir_d;
      rr_ptr_q    <= rr_ptr_d;
      rrd_cnt_q   <= rrd_cnt_d;
      ccd_cnt_q   <= ccd_cnt_d;
      wtr_cnt_q   <= wtr_cnt_d;
      rtw_cnt_q   <= rtw_cnt_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_addr  = cmd_addr_q;
  assign bus_dir   = (dir_q == DIR_WR);

endmodule

// File: doc/bank_cmd_arbiter.md
Name: bank_cmd_arbiter

Overview:
Shares the single DRAM command/address bus among NUM_BANKS bank FSMs. Each cycle it:
- selects at most one bank whose ba_issue is high;
- holds every other issuing bank with stall;
- enforces inter-bank timing (tRRD, tCCD, write-to-read, read-to-write);
- drives one registered command onto the PHY-side bus.

It sits between the bank_FSM array and the command encoder/PHY, and it is the source of each bank's stall input.

Parameters:
NUM_BANKS, 8, number of bank FSMs served; power of two, 2..16
ADDR_BITS, 16, width of bank address field
T_RRD, 2, minimum cycles between ACT commands to different banks
T_CCD, 2, minimum cycles between any two RD/WR commands
T_WTR, 4, minimum cycles from WR issue to the next RD
T_RTW, 3, minimum cycles from RD issue to the next WR
CNT_W, 4, width of timing counters; every T_* value must be between 1 and 2^CNT_W-1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ba_issue  in  NUM_BANKS  bank i requests the bus this cycle
ba_cmd  in  NUM_BANKS*3  per-bank cmd_code_t (NOP/ACT/RD/WR/PRE/REF)
ba_addr  in  NUM_BANKS*ADDR_BITS  per-bank row or column address
stall  out  NUM_BANKS  bank i must hold state (combinational)
cmd_valid  out  1  registered: command on bus this cycle
cmd_code  out  3  registered: issued cmd_code_t
cmd_bank  out  log2(NUM_BANKS)  registered: issuing bank index
cmd_addr  out  ADDR_BITS  registered: issuing address
bus_dir  out  1  current data direction (0=read, 1=write)

Behaviour:
- Reset: cmd_valid=0, cmd_code=NOP, cmd_bank=0, cmd_addr=0, bus_dir=0, rr_ptr=0, all timing counters=0.
  - stall is combinational; it is 0 while rst_n=0.
- Eligibility: bank i is eligible iff ba_issue[i]=1 and its command passes the timing checks:
  - ACT requires rrd_cnt==0.
  - RD requires ccd_cnt==0 and wtr_cnt==0.
  - WR requires ccd_cnt==0 and rtw_cnt==0.
  - PRE and REF are always eligible.
  - NOP with ba_issue=1 is never eligible.
- Priority:
  - Any eligible REF wins first, lowest index among REF requesters.
  - Otherwise round-robin among eligible banks, searching from rr_ptr upward with wrap.
- Grant:
  - stall[g]=0 for the winner g.
  - stall[i]=1 for every other bank with ba_issue[i]=1.
  - stall[i]=0 for every bank with ba_issue[i]=0, so non-issuing states keep advancing.
  - No eligible bank means no grant, and every issuing bank is stalled.
- Latency: a grant in cycle n appears on cmd_* with cmd_valid=1 in cycle n+1. With no grant, the next cycle shows cmd_valid=0 and cmd_code=NOP; cmd_bank and cmd_addr hold their previous values.
- rr_ptr: on a non-REF grant, rr_ptr <= (g+1) mod NUM_BANKS. On a REF grant or no grant, rr_ptr is unchanged.
- Timing counters: on a grant of the matching command at edge n, load T_x-1; otherwise decrement, saturating at 0. The command is allowed again from cycle n+T_x.
  - ACT loads rrd_cnt.
  - RD loads ccd_cnt and rtw_cnt.
  - WR loads ccd_cnt and wtr_cnt.
  - Multiple counters may load on the same edge.
- Direction FSM, states DIR_RD and DIR_WR, reset DIR_RD:
  - A granted WR moves it to DIR_WR; a granted RD moves it to DIR_RD.
  - bus_dir is 1 in DIR_WR.
  - It is informational only; legality comes from the counters.
- Boundaries:
  - With a single requester, that requester wins whenever it is eligible.
  - Two REFs in the same cycle: the lower index wins, the other is stalled.
  - At most one grant per cycle, always.
  - A request whose ba_issue deasserts without a grant produces no command.
  - Reset asserted mid-operation clears all state immediately; no partial command is emitted after reset.

Decomposition:
- Shared package:
  - cmd_code_t enum: NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5.
  - dir_t enum: DIR_RD, DIR_WR.
  - Default T_* constants.
- Sub-module rr_arbiter: parameterized NUM_BANKS round-robin picker with inputs req vector and ptr, and outputs one-hot grant plus index.

Test Plan:
- Bank 0 and bank 3 both issue ACT in cycle 5, rr_ptr=0 → stall[0]=0, stall[3]=1; cycle 6 shows cmd_code=ACT, cmd_bank=0. Bank 3 ACT cannot be granted before cycle 7 (T_RRD=2).
- Bank 1 WR granted at cycle 10, bank 2 RD pending → RD stalled through cycle 13 and granted at cycle 14 (T_WTR=4); bus_dir goes 1 at cycle 11 and 0 at cycle 15.
- Banks 0–7 all issue PRE continuously → grants rotate 0,1,…,7,0 with one command per cycle and cmd_valid=1 every cycle.
- Banks 2 and 5 issue REF while bank 0 issues RD → bank 2 wins, then bank 5, then bank 0; rr_ptr is unchanged by the REF grants.
- Back-to-back RD from banks 0 and 1 → grants at cycles n and n+2 (T_CCD=2), with cmd_valid=0 at n+2 on the bus.
- rst_n pulsed low while requests are pending → all cmd_* outputs and rr_ptr return to reset values at once; the first grant after release follows rr_ptr=0.
